// File: rtl/inbuf_mem_sched_pkg.sv
// Shared definitions for the input buffer memory scheduler.
// Contents: memory geometry, arbitration limits, FSM state enum,
// level/pointer/counter types and the grant vector bit positions.
package inbuf_mem_sched_pkg;

  localparam int INBUF_MEM_DATA_W = 512;
  localparam int INBUF_MEM_ADDR_W = 6;
  localparam int INBUF_DEPTH      = 1 << INBUF_MEM_ADDR_W;
  localparam int STARVE_MAX       = 4;
  localparam int RD_INFLIGHT_MAX  = 3;

  localparam int STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam int INFLIGHT_W = $clog2(RD_INFLIGHT_MAX + 1);

  // Bit positions inside the one-hot grant vector from the arbiter
  localparam int GRANT_RD = 0;
  localparam int GRANT_WR = 1;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

  typedef logic [INBUF_MEM_ADDR_W:0]   inbuf_level_t;
  typedef logic [INBUF_MEM_ADDR_W-1:0] inbuf_addr_t;
  typedef logic [STARVE_W-1:0]         starve_t;
  typedef logic [INFLIGHT_W-1:0]       inflight_t;

  localparam inbuf_level_t LEVEL_FULL     = inbuf_level_t'(INBUF_DEPTH);
  localparam starve_t      STARVE_LIMIT   = starve_t'(STARVE_MAX);
  localparam inflight_t    INFLIGHT_LIMIT = inflight_t'(RD_INFLIGHT_MAX);

endpackage

// File: rtl/inbuf_sched_arb.sv
// Two-requester priority arbiter for the input buffer memory port.
// Reads normally win; a write that has lost STARVE_MAX consecutive
// arbitrations wins the next one.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear of the starve counter (engine reset)
//   rd_elig   : read is eligible this cycle
//   wr_elig   : write is eligible this cycle
//   wr_req    : raw host write request (low clears the starve counter)
//   grant     : one-hot grant, bit GRANT_RD = read, bit GRANT_WR = write
module inbuf_sched_arb
  import inbuf_mem_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       rd_elig,
  input  logic       wr_elig,
  input  logic       wr_req,
  output logic [1:0] grant
);

  starve_t starve_cnt;
  logic    wr_first;

  always_comb begin
    grant    = 2'b00;
    wr_first = (starve_cnt >= STARVE_LIMIT);
    if (wr_elig && (wr_first || !rd_elig)) begin
      grant[GRANT_WR] = 1'b1;
    end else if (rd_elig) begin
      grant[GRANT_RD] = 1'b1;
    end
  end

  // An eligible write without a write grant has necessarily lost to a read.
  // A write blocked by a full buffer is not eligible and so never counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (clr || grant[GRANT_WR] || !wr_req) begin
      starve_cnt <= '0;
    end else if (wr_elig && (starve_cnt != STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/inbuf_mem_sched.sv
// Input buffer memory scheduler: shares the single-port input buffer
// memory between the host write stream and controller line reads.
// Owns the circular pointers, occupancy level, full/empty flags and the
// RUN/DRAIN engine-reset FSM that swallows stale read returns.
// Optional feature macro: INBUF_SCHED_PERF_EN (stall performance counters;
// when undefined both perf ports are tied to 0).
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   eng_rst                   : synchronous engine soft reset
//   host_wr_req/data/ack      : host write handshake (ack is a pulse)
//   cntl_rd_req/grant         : controller read handshake (grant is a pulse)
//   cntl_rd_data_val          : filtered, registered memory data valid
//   inbuf_mem_rd_data_val     : memory read data valid
//   inbuf_mem_rd_req/wr_req   : memory strobes
//   inbuf_mem_rd_addr/wr_addr : memory addresses
//   inbuf_mem_wr_data         : memory write data
//   inbuf_full/empty/level    : occupancy
//   perf_rd/wr_stall_cnt      : stall counters
module inbuf_mem_sched
  import inbuf_mem_sched_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        eng_rst,
  input  logic                        host_wr_req,
  input  logic [INBUF_MEM_DATA_W-1:0] host_wr_data,
  output logic                        host_wr_ack,
  input  logic                        cntl_rd_req,
  output logic                        cntl_rd_grant,
  output logic                        cntl_rd_data_val,
  input  logic                        inbuf_mem_rd_data_val,
  output logic                        inbuf_mem_rd_req,
  output logic                        inbuf_mem_wr_req,
  output logic [INBUF_MEM_ADDR_W-1:0] inbuf_mem_rd_addr,
  output logic [INBUF_MEM_ADDR_W-1:0] inbuf_mem_wr_addr,
  output logic [INBUF_MEM_DATA_W-1:0] inbuf_mem_wr_data,
  output logic                        inbuf_full,
  output logic                        inbuf_empty,
  output logic [INBUF_MEM_ADDR_W:0]   inbuf_level,
  output logic [15:0]                 perf_rd_stall_cnt,
  output logic [15:0]                 perf_wr_stall_cnt
);

  sched_state_t state, state_next;
  inbuf_addr_t  wr_ptr, rd_ptr;
  inbuf_level_t level;
  inflight_t    inflight, inflight_next;
  logic         rd_elig, wr_elig, rd_win, wr_win, rd_ret;
  logic [1:0]   grant;

  assign inbuf_level = level;
  assign inbuf_full  = (level == LEVEL_FULL);
  assign inbuf_empty = (level == '0);

  assign rd_elig = cntl_rd_req && !inbuf_empty && (state == RUN) &&
                   (inflight < INFLIGHT_LIMIT);
  assign wr_elig = host_wr_req && !inbuf_full && (state == RUN);

  inbuf_sched_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .clr     (eng_rst),
    .rd_elig (rd_elig),
    .wr_elig (wr_elig),
    .wr_req  (host_wr_req),
    .grant   (grant)
  );

  // A decision taken in the engine-reset cycle is thrown away.
  assign rd_win = grant[GRANT_RD] && !eng_rst;
  assign wr_win = grant[GRANT_WR] && !eng_rst;

  // A return with nothing outstanding is spurious and must not underflow.
  assign rd_ret = inbuf_mem_rd_data_val && (inflight != '0);

  // The in-flight count rises on the same edge that raises the registered
  // read strobe, so eligibility always sees every read already committed.
  always_comb begin
    inflight_next = inflight;
    if (rd_win && !rd_ret) begin
      inflight_next = inflight + 1'b1;
    end else if (!rd_win && rd_ret) begin
      inflight_next = inflight - 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (eng_rst && ((inflight != '0) || inbuf_mem_rd_req)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!eng_rst && (inflight_next == '0)) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      inflight <= '0;
    end else begin
      state    <= state_next;
      inflight <= inflight_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_wr_ack       <= 1'b0;
      cntl_rd_grant     <= 1'b0;
      cntl_rd_data_val  <= 1'b0;
      inbuf_mem_rd_req  <= 1'b0;
      inbuf_mem_wr_req  <= 1'b0;
      inbuf_mem_rd_addr <= '0;
      inbuf_mem_wr_addr <= '0;
      inbuf_mem_wr_data <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      level             <= '0;
    end else begin
      host_wr_ack      <= wr_win;
      cntl_rd_grant    <= rd_win;
      inbuf_mem_wr_req <= wr_win;
      inbuf_mem_rd_req <= rd_win;
      cntl_rd_data_val <= rd_ret && (state == RUN) && !eng_rst;
      if (eng_rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else if (wr_win) begin
        inbuf_mem_wr_addr <= wr_ptr;
        inbuf_mem_wr_data <= host_wr_data;
        wr_ptr            <= wr_ptr + 1'b1;
        level             <= level + 1'b1;
      end else if (rd_win) begin
        inbuf_mem_rd_addr <= rd_ptr;
        rd_ptr            <= rd_ptr + 1'b1;
        level             <= level - 1'b1;
      end
    end
  end

`ifdef INBUF_SCHED_PERF_EN
  logic [15:0] perf_rd, perf_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_rd <= '0;
      perf_wr <= '0;
    end else if (eng_rst) begin
      perf_rd <= '0;
      perf_wr <= '0;
    end else begin
      if (cntl_rd_req && !rd_win && (perf_rd != 16'hFFFF)) begin
        perf_rd <= perf_rd + 1'b1;
      end
      if (host_wr_req && !wr_win && (perf_wr != 16'hFFFF)) begin
        perf_wr <= perf_wr + 1'b1;
      end
    end
  end

  assign perf_rd_stall_cnt = perf_rd;
  assign perf_wr_stall_cnt = perf_wr;
`else
  assign perf_rd_stall_cnt = 16'h0000;
  assign perf_wr_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_inbuf_mem_sched.sv
// Self-checking bench for inbuf_mem_sched: directed scenarios with
// hand-derived expectations, one task per scenario.
module tb_inbuf_mem_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         eng_rst;
  logic         host_wr_req;
  logic [511:0] host_wr_data;
  logic         host_wr_ack;
  logic         cntl_rd_req;
  logic         cntl_rd_grant;
  logic         cntl_rd_data_val;
  logic         inbuf_mem_rd_data_val;
  logic         inbuf_mem_rd_req;
  logic         inbuf_mem_wr_req;
  logic [5:0]   inbuf_mem_rd_addr;
  logic [5:0]   inbuf_mem_wr_addr;
  logic [511:0] inbuf_mem_wr_data;
  logic         inbuf_full;
  logic         inbuf_empty;
  logic [6:0]   inbuf_level;
  logic [15:0]  perf_rd_stall_cnt;
  logic [15:0]  perf_wr_stall_cnt;

  int pass_cnt  = 0;
  int check_cnt = 0;

`ifdef INBUF_SCHED_PERF_EN
  localparam int PERF_RD_EXP = 10;
`else
  localparam int PERF_RD_EXP = 0;
`endif

  inbuf_mem_sched dut (
    .clk                   (clk),
    .rst                   (rst),
    .eng_rst               (eng_rst),
    .host_wr_req           (host_wr_req),
    .host_wr_data          (host_wr_data),
    .host_wr_ack           (host_wr_ack),
    .cntl_rd_req           (cntl_rd_req),
    .cntl_rd_grant         (cntl_rd_grant),
    .cntl_rd_data_val      (cntl_rd_data_val),
    .inbuf_mem_rd_data_val (inbuf_mem_rd_data_val),
    .inbuf_mem_rd_req      (inbuf_mem_rd_req),
    .inbuf_mem_wr_req      (inbuf_mem_wr_req),
    .inbuf_mem_rd_addr     (inbuf_mem_rd_addr),
    .inbuf_mem_wr_addr     (inbuf_mem_wr_addr),
    .inbuf_mem_wr_data     (inbuf_mem_wr_data),
    .inbuf_full            (inbuf_full),
    .inbuf_empty           (inbuf_empty),
    .inbuf_level           (inbuf_level),
    .perf_rd_stall_cnt     (perf_rd_stall_cnt),
    .perf_wr_stall_cnt     (perf_wr_stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    eng_rst = 1'b0;
    host_wr_req = 1'b0;
    host_wr_data = '0;
    cntl_rd_req = 1'b0;
    inbuf_mem_rd_data_val = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Stream n lines into an otherwise idle scheduler
  task automatic write_lines(input int n);
    for (int i = 0; i < n; i++) begin
      host_wr_req = 1'b1;
      host_wr_data = {16{32'(i)}};
      tick();
    end
    host_wr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    eng_rst = 1'b0;
    host_wr_req = 1'b0;
    host_wr_data = '0;
    cntl_rd_req = 1'b0;
    inbuf_mem_rd_data_val = 1'b0;
    tick();
    check_cnt++;
    if ({host_wr_ack, cntl_rd_grant, cntl_rd_data_val, inbuf_mem_rd_req, inbuf_mem_wr_req} !== 5'b0) begin
      $display("[TB] FAIL reset_strobes: got %b expected 00000",
               {host_wr_ack, cntl_rd_grant, cntl_rd_data_val, inbuf_mem_rd_req, inbuf_mem_wr_req});
    end else pass_cnt++;
    check_cnt++;
    if (inbuf_level !== 7'd0 || inbuf_empty !== 1'b1 || inbuf_full !== 1'b0) begin
      $display("[TB] FAIL reset_level: got level=%0d empty=%b full=%b expected 0/1/0",
               inbuf_level, inbuf_empty, inbuf_full);
    end else pass_cnt++;
    check_cnt++;
    if (inbuf_mem_rd_addr !== 6'd0 || inbuf_mem_wr_addr !== 6'd0 || perf_rd_stall_cnt !== 16'd0 ||
        perf_wr_stall_cnt !== 16'd0) begin
      $display("[TB] FAIL reset_regs: got rd_addr=%0d wr_addr=%0d perf=%0d/%0d expected all 0",
               inbuf_mem_rd_addr, inbuf_mem_wr_addr, perf_rd_stall_cnt, perf_wr_stall_cnt);
    end else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_fill();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      host_wr_req = 1'b1;
      host_wr_data = {16{32'(i) ^ 32'hA5A5_0000}};
      tick();
      check_cnt++;
      if (host_wr_ack !== 1'b1 || inbuf_mem_wr_req !== 1'b1 || inbuf_mem_wr_addr !== 6'(i) ||
          inbuf_mem_wr_data !== {16{32'(i) ^ 32'hA5A5_0000}} || inbuf_level !== 7'(i + 1)) begin
        $display("[TB] FAIL fill_write_%0d: got ack=%b strobe=%b addr=%0d level=%0d expected 1/1/%0d/%0d",
                 i, host_wr_ack, inbuf_mem_wr_req, inbuf_mem_wr_addr, inbuf_level, i, i + 1);
      end else pass_cnt++;
    end
    check_cnt++;
    if (inbuf_full !== 1'b1 || inbuf_empty !== 1'b0 || inbuf_level !== 7'd64) begin
      $display("[TB] FAIL fill_full: got full=%b empty=%b level=%0d expected 1/0/64",
               inbuf_full, inbuf_empty, inbuf_level);
    end else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_cnt++;
      if (host_wr_ack !== 1'b0 || inbuf_mem_wr_req !== 1'b0 || inbuf_level !== 7'd64) begin
        $display("[TB] FAIL fill_65th_cycle%0d: got ack=%b strobe=%b level=%0d expected 0/0/64",
                 c, host_wr_ack, inbuf_mem_wr_req, inbuf_level);
      end else pass_cnt++;
    end
    host_wr_req = 1'b0;
    tick();
  endtask

  // Runs straight after test_write_fill with the buffer full
  task automatic test_read_wrap();
    int rd_n = 0;
    int wr_n = 0;
    int lvl = 64;
    host_wr_req = 1'b1;
    host_wr_data = {16{32'hDEAD_BEEF}};
    cntl_rd_req = 1'b1;
    for (int cyc = 0; cyc < 300 && rd_n < 70; cyc++) begin
      tick();
      inbuf_mem_rd_data_val = inbuf_mem_rd_req;
      check_cnt++;
      if (cntl_rd_grant && host_wr_ack) begin
        $display("[TB] FAIL wrap_exclusive: got both grants in cycle %0d expected at most one", cyc);
      end else pass_cnt++;
      if (cntl_rd_grant) begin
        check_cnt++;
        if (inbuf_mem_rd_addr !== 6'(rd_n) || inbuf_mem_rd_req !== 1'b1) begin
          $display("[TB] FAIL wrap_rd_addr_%0d: got addr=%0d strobe=%b expected %0d/1",
                   rd_n, inbuf_mem_rd_addr, inbuf_mem_rd_req, rd_n % 64);
        end else pass_cnt++;
        rd_n++;
        lvl--;
      end
      if (host_wr_ack) begin
        if (wr_n == 0) begin
          // Reads blocked the write while full without building starvation
          check_cnt++;
          if (rd_n !== 5) begin
            $display("[TB] FAIL wrap_first_write: got after %0d reads expected 5", rd_n);
          end else pass_cnt++;
        end
        check_cnt++;
        if (inbuf_mem_wr_addr !== 6'(wr_n)) begin
          $display("[TB] FAIL wrap_wr_addr_%0d: got %0d expected %0d", wr_n, inbuf_mem_wr_addr, wr_n % 64);
        end else pass_cnt++;
        wr_n++;
        lvl++;
      end
      check_cnt++;
      if (inbuf_level !== 7'(lvl) || lvl > 64 || lvl < 0) begin
        $display("[TB] FAIL wrap_level: got %0d expected %0d within 0..64", inbuf_level, lvl);
      end else pass_cnt++;
      if (rd_n == 70) cntl_rd_req = 1'b0;
    end
    check_cnt++;
    if (rd_n !== 70) begin
      $display("[TB] FAIL wrap_timeout: got %0d reads expected 70", rd_n);
    end else pass_cnt++;
    host_wr_req = 1'b0;
    cntl_rd_req = 1'b0;
    tick();
    inbuf_mem_rd_data_val = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    do_reset();
    write_lines(10);
    tick();
    host_wr_req = 1'b1;
    cntl_rd_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      inbuf_mem_rd_data_val = inbuf_mem_rd_req;
      check_cnt++;
      if ((k % 5) == 4) begin
        if (host_wr_ack !== 1'b1 || cntl_rd_grant !== 1'b0) begin
          $display("[TB] FAIL starve_grant_%0d: got wr=%b rd=%b expected wr=1 rd=0", k, host_wr_ack, cntl_rd_grant);
        end else pass_cnt++;
      end else begin
        if (host_wr_ack !== 1'b0 || cntl_rd_grant !== 1'b1) begin
          $display("[TB] FAIL starve_grant_%0d: got wr=%b rd=%b expected wr=0 rd=1", k, host_wr_ack, cntl_rd_grant);
        end else pass_cnt++;
      end
    end
    host_wr_req = 1'b0;
    cntl_rd_req = 1'b0;
    check_cnt++;
    if (inbuf_level !== 7'd4) begin
      $display("[TB] FAIL starve_level: got %0d expected 4", inbuf_level);
    end else pass_cnt++;
    tick();
    inbuf_mem_rd_data_val = 1'b0;
    tick();
  endtask

  task automatic test_empty_read();
    do_reset();
    cntl_rd_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_cnt++;
      if (cntl_rd_grant !== 1'b0 || inbuf_mem_rd_req !== 1'b0) begin
        $display("[TB] FAIL empty_no_grant_%0d: got grant=%b strobe=%b expected 0/0", c, cntl_rd_grant, inbuf_mem_rd_req);
      end else pass_cnt++;
    end
    host_wr_req = 1'b1;
    host_wr_data = {16{32'h1234_5678}};
    tick();
    host_wr_req = 1'b0;
    check_cnt++;
    if (host_wr_ack !== 1'b1 || cntl_rd_grant !== 1'b0 || inbuf_level !== 7'd1) begin
      $display("[TB] FAIL empty_first_write: got ack=%b grant=%b level=%0d expected 1/0/1",
               host_wr_ack, cntl_rd_grant, inbuf_level);
    end else pass_cnt++;
    tick();
    cntl_rd_req = 1'b0;
    check_cnt++;
    if (cntl_rd_grant !== 1'b1 || inbuf_mem_rd_req !== 1'b1 || inbuf_mem_rd_addr !== 6'd0 || inbuf_level !== 7'd0) begin
      $display("[TB] FAIL empty_then_read: got grant=%b strobe=%b addr=%0d level=%0d expected 1/1/0/0",
               cntl_rd_grant, inbuf_mem_rd_req, inbuf_mem_rd_addr, inbuf_level);
    end else pass_cnt++;
    inbuf_mem_rd_data_val = 1'b1;
    tick();
    inbuf_mem_rd_data_val = 1'b0;
    check_cnt++;
    if (cntl_rd_data_val !== 1'b1) begin
      $display("[TB] FAIL data_val_pass: got %b expected 1", cntl_rd_data_val);
    end else pass_cnt++;
    tick();
    check_cnt++;
    if (cntl_rd_data_val !== 1'b0) begin
      $display("[TB] FAIL data_val_pulse: got %b expected 0", cntl_rd_data_val);
    end else pass_cnt++;
  endtask

  task automatic test_eng_rst_drain();
    do_reset();
    write_lines(4);
    cntl_rd_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check_cnt++;
      if (cntl_rd_grant !== 1'b1 || inbuf_mem_rd_addr !== 6'(c)) begin
        $display("[TB] FAIL drain_setup_read_%0d: got grant=%b addr=%0d expected 1/%0d",
                 c, cntl_rd_grant, inbuf_mem_rd_addr, c);
      end else pass_cnt++;
    end
    eng_rst = 1'b1;
    host_wr_req = 1'b1;
    tick();
    eng_rst = 1'b0;
    check_cnt++;
    if (host_wr_ack !== 1'b0 || cntl_rd_grant !== 1'b0 || inbuf_mem_rd_req !== 1'b0 || inbuf_level !== 7'd0) begin
      $display("[TB] FAIL drain_engrst_cycle: got ack=%b grant=%b strobe=%b level=%0d expected 0/0/0/0",
               host_wr_ack, cntl_rd_grant, inbuf_mem_rd_req, inbuf_level);
    end else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      inbuf_mem_rd_data_val = (c != 1);
      tick();
      check_cnt++;
      if (cntl_rd_data_val !== 1'b0 || host_wr_ack !== 1'b0 || cntl_rd_grant !== 1'b0 || inbuf_level !== 7'd0) begin
        $display("[TB] FAIL drain_cycle_%0d: got val=%b ack=%b grant=%b level=%0d expected 0/0/0/0",
                 c, cntl_rd_data_val, host_wr_ack, cntl_rd_grant, inbuf_level);
      end else pass_cnt++;
    end
    inbuf_mem_rd_data_val = 1'b0;
    tick();
    host_wr_req = 1'b0;
    cntl_rd_req = 1'b0;
    check_cnt++;
    if (host_wr_ack !== 1'b1 || inbuf_mem_wr_addr !== 6'd0 || cntl_rd_grant !== 1'b0) begin
      $display("[TB] FAIL drain_back_to_run: got ack=%b wr_addr=%0d grant=%b expected 1/0/0",
               host_wr_ack, inbuf_mem_wr_addr, cntl_rd_grant);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_spurious_and_inflight();
    int grants = 0;
    do_reset();
    inbuf_mem_rd_data_val = 1'b1;
    tick();
    inbuf_mem_rd_data_val = 1'b0;
    check_cnt++;
    if (cntl_rd_data_val !== 1'b0) begin
      $display("[TB] FAIL spurious_val: got %b expected 0", cntl_rd_data_val);
    end else pass_cnt++;
    write_lines(5);
    cntl_rd_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cntl_rd_grant) grants++;
    end
    cntl_rd_req = 1'b0;
    check_cnt++;
    if (grants !== 3 || inbuf_level !== 7'd2) begin
      $display("[TB] FAIL inflight_limit: got grants=%0d level=%0d expected 3/2", grants, inbuf_level);
    end else pass_cnt++;
    inbuf_mem_rd_data_val = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_cnt++;
      if (cntl_rd_data_val !== 1'b1) begin
        $display("[TB] FAIL inflight_return_%0d: got %b expected 1", c, cntl_rd_data_val);
      end else pass_cnt++;
    end
    inbuf_mem_rd_data_val = 1'b0;
    tick();
  endtask

  task automatic test_perf();
    do_reset();
    cntl_rd_req = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    cntl_rd_req = 1'b0;
    check_cnt++;
    if (perf_rd_stall_cnt !== 16'(PERF_RD_EXP)) begin
      $display("[TB] FAIL perf_rd_stall: got %0d expected %0d", perf_rd_stall_cnt, PERF_RD_EXP);
    end else pass_cnt++;
    check_cnt++;
    if (perf_wr_stall_cnt !== 16'd0) begin
      $display("[TB] FAIL perf_wr_stall: got %0d expected 0", perf_wr_stall_cnt);
    end else pass_cnt++;
    eng_rst = 1'b1;
    tick();
    eng_rst = 1'b0;
    check_cnt++;
    if (perf_rd_stall_cnt !== 16'd0) begin
      $display("[TB] FAIL perf_clear: got %0d expected 0", perf_rd_stall_cnt);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_fill();
    test_read_wrap();
    test_starvation();
    test_empty_read();
    test_eng_rst_drain();
    test_spurious_and_inflight();
    test_perf();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
